// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - encodes instruction field bundles into 9-bit X9 words and streams them to imem
// A small FIFO decouples bundle acceptance from memory write back-pressure.
module instr_encoder #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [4:0]        mnem,
  input  logic [3:0]        ra,
  input  logic [3:0]        rb,
  input  logic [3:0]        imm,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [8:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              wrapped
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [8:0]        mem_q [FIFO_DEPTH];
  logic [8:0]        mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic              wrapped_q, wrapped_d;

  logic [8:0] enc_word;
  logic       enc_legal;
  logic       fifo_empty;
  logic       accept;
  logic       push;
  logic       pop;

  // movr/movi only have room for a 3-bit destination, so ra[3] must be clear
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b0;
    if (mnem < 5'd16) begin
      enc_word  = {mnem, ra};
      enc_legal = 1'b1;
    end else if (mnem == 5'd16) begin
      enc_word  = {2'b10, ra[2:0], rb};
      enc_legal = !ra[3];
    end else if (mnem == 5'd17) begin
      enc_word  = {2'b11, ra[2:0], imm};
      enc_legal = !ra[3];
    end
  end

  assign fifo_empty = (count_q == '0);
  assign in_ready   = (state_q == RUN) && (count_q < CNT_W'(FIFO_DEPTH));
  assign accept     = in_valid && in_ready;
  assign push       = accept && enc_legal;
  assign wr_en      = !fifo_empty;
  assign pop        = wr_en && wr_ready;
  assign wr_data    = fifo_empty ? 9'd0 : mem_q[rd_ptr_q];
  assign wr_addr    = addr_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DRAIN) && fifo_empty;
  assign err        = err_q;
  assign wrapped    = wrapped_q;

  always_comb begin
    state_d   = state_q;
    mem_d     = mem_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
    addr_d    = addr_q;
    err_d     = err_q;
    wrapped_d = wrapped_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          addr_d    = base_addr;
          err_d     = 1'b0;
          wrapped_d = 1'b0;
        end
      end
      RUN: begin
        if (accept && in_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept && !enc_legal) err_d = 1'b1;

    if (push) begin
      mem_d[wr_ptr_q] = enc_word;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    // The FIFO is always empty in IDLE, so a pop never races a start
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      addr_d   = addr_q + ADDR_W'(1);
      if (addr_q == '1) wrapped_d = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q   <= IDLE;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      addr_q    <= '0;
      err_q     <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
      wrapped_q <= wrapped_d;
    end
  end

  always_ff @(posedge Clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - table-driven bench for instr_encoder
module tb_instr_encoder;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] base_addr = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_last = 1'b0;
  logic [4:0] mnem = 5'd0;
  logic [3:0] ra = 4'd0;
  logic [3:0] rb = 4'd0;
  logic [3:0] imm = 4'd0;
  logic       wr_en;
  logic       wr_ready = 1'b0;
  logic [7:0] wr_addr;
  logic [8:0] wr_data;
  logic       busy;
  logic       done;
  logic       err;
  logic       wrapped;

  always #5 Clk = ~Clk;

  instr_encoder #(.ADDR_W(8), .FIFO_DEPTH(4)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .mnem(mnem), .ra(ra), .rb(rb), .imm(imm),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err), .wrapped(wrapped)
  );

  typedef struct {
    logic [4:0] mnem;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] imm;
    logic       legal;
    logic [8:0] word;
  } vec_t;

  typedef struct {
    logic [7:0] addr;
    logic [8:0] data;
  } wr_t;

  vec_t vecs [18];
  wr_t  log_q [$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_wr_cyc = -1;
  int   done_cyc = -1;

  always @(negedge Clk) begin
    cyc++;
    if (Reset && wr_en && wr_ready) begin
      log_q.push_back('{wr_addr, wr_data});
      last_wr_cyc = cyc;
    end
    if (Reset && done) done_cyc = cyc;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int i, input logic last);
    mnem     = vecs[i].mnem;
    ra       = vecs[i].ra;
    rb       = vecs[i].rb;
    imm      = vecs[i].imm;
    in_last  = last;
    in_valid = 1'b1;
  endtask

  task automatic send(input int i, input logic last);
    int n = 0;
    drive(i, last);
    while (!in_ready && n < 100) begin
      @(posedge Clk); #1;
      n++;
    end
    check($sformatf("accept_timeout_vec%0d", i), 32'(n >= 100), 32'd0);
    @(posedge Clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic start_load(input logic [7:0] base);
    start     = 1'b1;
    base_addr = base;
    @(posedge Clk); #1;
    start     = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!done && n < 100);
    check("done_seen", done, 1'b1);
    @(posedge Clk); #1;
  endtask

  task automatic check_log(input string tag, input logic [7:0] base, input int first, input int n);
    int k = 0;
    logic [7:0] a;
    for (int i = first; i < first + n; i++) begin
      if (vecs[i].legal) begin
        a = base + 8'(k);
        if (k < log_q.size()) begin
          check($sformatf("%s_data%0d", tag, k), log_q[k].data, vecs[i].word);
          check($sformatf("%s_addr%0d", tag, k), log_q[k].addr, a);
        end
        k++;
      end
    end
    check($sformatf("%s_nwrites", tag), log_q.size(), k);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{5'd0,  4'd3,  4'd0,  4'd0,  1'b1, 9'h003};
    vecs[1]  = '{5'd1,  4'd15, 4'd0,  4'd0,  1'b1, 9'h01F};
    vecs[2]  = '{5'd16, 4'd2,  4'd5,  4'd0,  1'b1, 9'h125};
    vecs[3]  = '{5'd17, 4'd7,  4'd0,  4'd9,  1'b1, 9'h1F9};
    vecs[4]  = '{5'd18, 4'd1,  4'd0,  4'd0,  1'b0, 9'h000};
    vecs[5]  = '{5'd16, 4'd8,  4'd3,  4'd0,  1'b0, 9'h000};
    vecs[6]  = '{5'd17, 4'd9,  4'd0,  4'd1,  1'b0, 9'h000};
    vecs[7]  = '{5'd13, 4'd1,  4'd0,  4'd0,  1'b1, 9'h0D1};
    vecs[8]  = '{5'd2,  4'd1,  4'd0,  4'd0,  1'b1, 9'h021};
    vecs[9]  = '{5'd5,  4'd10, 4'd0,  4'd0,  1'b1, 9'h05A};
    vecs[10] = '{5'd16, 4'd5,  4'd12, 4'd0,  1'b1, 9'h15C};
    vecs[11] = '{5'd17, 4'd0,  4'd0,  4'd15, 1'b1, 9'h18F};
    vecs[12] = '{5'd15, 4'd15, 4'd0,  4'd0,  1'b1, 9'h0FF};
    vecs[13] = '{5'd0,  4'd0,  4'd0,  4'd0,  1'b1, 9'h000};
    vecs[14] = '{5'd7,  4'd4,  4'd0,  4'd0,  1'b1, 9'h074};
    vecs[15] = '{5'd17, 4'd3,  4'd0,  4'd6,  1'b1, 9'h1B6};
    vecs[16] = '{5'd9,  4'd2,  4'd0,  4'd0,  1'b1, 9'h092};
    vecs[17] = '{5'd16, 4'd7,  4'd0,  4'd0,  1'b1, 9'h170};

    repeat (2) @(posedge Clk);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_wr_addr", wr_addr, 8'h00);
    check("rst_wr_data", wr_data, 9'h000);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_wrapped", wrapped, 1'b0);
    Reset = 1'b1;
    @(posedge Clk); #1;

    // basic program, no back-pressure
    log_q.delete();
    wr_ready = 1'b1;
    start_load(8'h10);
    check("t1_busy", busy, 1'b1);
    for (int i = 0; i < 4; i++) send(i, i == 3);
    wait_done();
    check_log("t1", 8'h10, 0, 4);
    check("t1_done_latency", 32'(done_cyc - last_wr_cyc), 32'd1);
    check("t1_idle", busy, 1'b0);

    // illegal bundles are dropped and flagged
    log_q.delete();
    start_load(8'h40);
    send(4, 1'b0);
    check("t3_err_after_first", err, 1'b1);
    for (int i = 5; i < 8; i++) send(i, i == 7);
    wait_done();
    check_log("t3", 8'h40, 4, 4);
    check("t3_addr_adv", wr_addr, 8'h41);
    check("t3_err_sticky", err, 1'b1);

    // back-pressure fills the FIFO
    log_q.delete();
    wr_ready = 1'b0;
    start_load(8'h20);
    check("t2_err_cleared", err, 1'b0);
    for (int i = 8; i < 12; i++) send(i, 1'b0);
    drive(12, 1'b1);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("t2_full_in_ready%0d", c), in_ready, 1'b0);
      check($sformatf("t2_hold_wr_en%0d", c), wr_en, 1'b1);
      check($sformatf("t2_hold_addr%0d", c), wr_addr, 8'h20);
      check($sformatf("t2_hold_data%0d", c), wr_data, vecs[8].word);
      @(posedge Clk); #1;
    end
    check("t2_no_writes_yet", log_q.size(), 0);
    wr_ready = 1'b1;
    send(12, 1'b1);
    wait_done();
    check_log("t2", 8'h20, 8, 5);

    // address wrap
    log_q.delete();
    start_load(8'hFE);
    check("t4_wrapped_clear", wrapped, 1'b0);
    for (int i = 13; i < 16; i++) send(i, i == 15);
    wait_done();
    check_log("t4", 8'hFE, 13, 3);
    check("t4_wrapped", wrapped, 1'b1);
    check("t4_final_addr", wr_addr, 8'h01);

    // start during RUN is ignored
    log_q.delete();
    start_load(8'h30);
    check("t6_wrapped_cleared", wrapped, 1'b0);
    send(16, 1'b0);
    start_load(8'h80);
    check("t6_busy", busy, 1'b1);
    send(17, 1'b1);
    wait_done();
    check_log("t6", 8'h30, 16, 2);
    check("t6_final_addr", wr_addr, 8'h32);

    // reset mid-load discards buffered words
    log_q.delete();
    wr_ready = 1'b0;
    start_load(8'h50);
    send(4, 1'b0);
    for (int i = 8; i < 11; i++) send(i, 1'b0);
    check("t5_pre_err", err, 1'b1);
    check("t5_pre_wr_en", wr_en, 1'b1);
    Reset = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b1;
    check("t5_wr_en", wr_en, 1'b0);
    check("t5_in_ready", in_ready, 1'b0);
    check("t5_busy", busy, 1'b0);
    check("t5_done", done, 1'b0);
    check("t5_err", err, 1'b0);
    check("t5_wrapped", wrapped, 1'b0);
    check("t5_wr_addr", wr_addr, 8'h00);
    check("t5_wr_data", wr_data, 9'h000);
    wr_ready = 1'b1;
    repeat (10) @(posedge Clk);
    #1;
    check("t5_no_writes", log_q.size(), 0);
    check("t5_wr_en_after", wr_en, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
